// File: rtl/ft601_rx_data_sink.sv
// Per-channel receive checker for the FT601 FIFO bridge: drains the RX FIFO and verifies a
// {channel, 24-bit sequence} word stream. Optional read throttling under SINK_THROTTLE_EN.
module ft601_rx_data_sink #(
    parameter int MAX_PACKET_SIZE = 1024,
    parameter int CHANNEL_NUM     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_rx_data,
    input  logic [3:0]  pc_rx_be,
    input  logic        pc_rx_valid,
    input  logic        pc_rx_empty,
    output logic        pc_rx_rd_en,
    output logic [31:0] rx_word_count,
    output logic [31:0] rx_packet_count,
    output logic [15:0] rx_err_count,
    output logic        rx_err,
    output logic [31:0] rx_first_err_data
);

    localparam int         WPP   = MAX_PACKET_SIZE / 4;
    localparam int         WIP_W = (WPP > 1) ? $clog2(WPP) : 1;
    localparam logic [7:0] CH_ID = 8'(CHANNEL_NUM);

    logic [23:0]      exp_seq_q, exp_seq_d;
    logic [WIP_W-1:0] word_in_pkt_q, word_in_pkt_d;
    logic [31:0]      word_count_q, word_count_d;
    logic [31:0]      packet_count_q, packet_count_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             err_q, err_d;
    logic [31:0]      first_err_q, first_err_d;

    logic             throttle_ok;
    logic [31:0]      expected_word;
    logic [3:0]       byte_bad;
    logic             word_err;
    logic             pkt_end;

`ifdef SINK_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; stalls reads whenever the low two bits are zero.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign throttle_ok = (lfsr_q[1:0] != 2'b00);
`else
    assign throttle_ok = 1'b1;
`endif

    assign pc_rx_rd_en   = !reset && !pc_rx_empty && throttle_ok;
    assign expected_word = {CH_ID, exp_seq_q};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_bad[gi] = pc_rx_be[gi] &&
                                  (pc_rx_data[8*gi +: 8] != expected_word[8*gi +: 8]);
        end
    endgenerate

    // A word with no enabled bytes carries nothing checkable, so it counts as an error.
    assign word_err = (pc_rx_be == 4'h0) || (|byte_bad);
    assign pkt_end  = (word_in_pkt_q == WIP_W'(WPP - 1)) || (pc_rx_be != 4'hF);

    always_comb begin
        exp_seq_d      = exp_seq_q;
        word_in_pkt_d  = word_in_pkt_q;
        word_count_d   = word_count_q;
        packet_count_d = packet_count_q;
        err_count_d    = err_count_q;
        err_d          = err_q;
        first_err_d    = first_err_q;

        if (pc_rx_valid) begin
            word_count_d = word_count_q + 32'd1;

            if (word_err) begin
                // Resync on the received value so one bad word yields one error.
                exp_seq_d = pc_rx_data[23:0] + 24'd1;
                err_d     = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                if (!err_q) begin
                    first_err_d = pc_rx_data;
                end
            end else begin
                exp_seq_d = exp_seq_q + 24'd1;
            end

            if (pkt_end) begin
                packet_count_d = packet_count_q + 32'd1;
                word_in_pkt_d  = '0;
            end else begin
                word_in_pkt_d  = word_in_pkt_q + WIP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_seq_q      <= '0;
            word_in_pkt_q  <= '0;
            word_count_q   <= '0;
            packet_count_q <= '0;
            err_count_q    <= '0;
            err_q          <= 1'b0;
            first_err_q    <= '0;
        end else begin
            exp_seq_q      <= exp_seq_d;
            word_in_pkt_q  <= word_in_pkt_d;
            word_count_q   <= word_count_d;
            packet_count_q <= packet_count_d;
            err_count_q    <= err_count_d;
            err_q          <= err_d;
            first_err_q    <= first_err_d;
        end
    end

    assign rx_word_count     = word_count_q;
    assign rx_packet_count   = packet_count_q;
    assign rx_err_count      = err_count_q;
    assign rx_err            = err_q;
    assign rx_first_err_data = first_err_q;

endmodule

// File: tb/tb_ft601_rx_data_sink.sv
// Self-checking bench for ft601_rx_data_sink (CHANNEL_NUM=2, 256 words per packet),
// checked against a word-level reference model of the sequence/packet rules.
module tb_ft601_rx_data_sink;

    localparam int CH  = 2;
    localparam int WPP = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_rx_data;
    logic [3:0]  pc_rx_be;
    logic        pc_rx_valid;
    logic        pc_rx_empty;
    logic        pc_rx_rd_en;
    logic [31:0] rx_word_count;
    logic [31:0] rx_packet_count;
    logic [15:0] rx_err_count;
    logic        rx_err;
    logic [31:0] rx_first_err_data;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int unsigned m_seq;
    int unsigned m_wip;
    int unsigned m_words;
    int unsigned m_pkts;
    int unsigned m_errs;
    bit          m_err;
    logic [31:0] m_first;

    ft601_rx_data_sink #(.MAX_PACKET_SIZE(1024), .CHANNEL_NUM(CH)) dut (
        .clk(clk), .reset(reset),
        .pc_rx_data(pc_rx_data), .pc_rx_be(pc_rx_be),
        .pc_rx_valid(pc_rx_valid), .pc_rx_empty(pc_rx_empty),
        .pc_rx_rd_en(pc_rx_rd_en),
        .rx_word_count(rx_word_count), .rx_packet_count(rx_packet_count),
        .rx_err_count(rx_err_count), .rx_err(rx_err),
        .rx_first_err_data(rx_first_err_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_seq = 0; m_wip = 0; m_words = 0; m_pkts = 0; m_errs = 0; m_err = 0; m_first = 0;
    endtask

    task automatic model_word(input logic [31:0] d, input logic [3:0] be);
        int unsigned expw;
        bit bad;
        expw = (CH << 24) | m_seq;
        bad  = (be == 4'h0);
        for (int i = 0; i < 4; i++)
            if (be[i] && (((d >> (8*i)) & 32'hFF) != ((expw >> (8*i)) & 32'hFF))) bad = 1;
        m_words++;
        if (bad) begin
            if (!m_err) m_first = d;
            m_err = 1;
            if (m_errs < 65535) m_errs++;
            m_seq = (d + 1) % (1 << 24);
        end else begin
            m_seq = (m_seq + 1) % (1 << 24);
        end
        if (m_wip == WPP - 1 || be != 4'hF) begin
            m_pkts++;
            m_wip = 0;
        end else begin
            m_wip++;
        end
    endtask

    // Called at a negedge; drives one cycle and returns at the following negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] be);
        pc_rx_valid = v; pc_rx_data = d; pc_rx_be = be;
        @(posedge clk);
        if (v) model_word(d, be);
        @(negedge clk);
        pc_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; pc_rx_valid = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_rx_empty = 1'b0; pc_rx_valid = 1'b0;
        pc_rx_data = '0; pc_rx_be = 4'hF;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (pc_rx_rd_en !== 1'b0) begin
                n_fail++; $display("FAIL reset_rd_en cycle %0d got %b want 0", i, pc_rx_rd_en);
            end
        end
        n_checks++;
        if (rx_word_count !== 0 || rx_packet_count !== 0 || rx_err_count !== 0 ||
            rx_err !== 1'b0 || rx_first_err_data !== 0) begin
            n_fail++;
            $display("FAIL reset_state got w=%0d p=%0d e=%0d err=%b first=%h want all 0",
                     rx_word_count, rx_packet_count, rx_err_count, rx_err, rx_first_err_data);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 32'h0, 4'hF);
            step(1'b1, 32'h02000000 + i, 4'hF);
        end
        n_checks++;
        if (rx_word_count !== 1024 || rx_packet_count !== 4 || rx_err_count !== 0 || rx_err !== 0) begin
            n_fail++;
            $display("FAIL in_order got w=%0d p=%0d e=%0d err=%b want w=1024 p=4 e=0 err=0",
                     rx_word_count, rx_packet_count, rx_err_count, rx_err);
        end
        $display("test_in_order: w=%0d p=%0d e=%0d", rx_word_count, rx_packet_count, rx_err_count);
    endtask

    task automatic test_corrupt();
        logic [31:0] seq_words [4];
        seq_words = '{32'h02000000, 32'h02000001, 32'h02000005, 32'h02000006};
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, seq_words[i], 4'hF);
        n_checks++;
        if (rx_err_count !== 1 || rx_err !== 1'b1 || rx_first_err_data !== 32'h02000005 ||
            rx_word_count !== 4) begin
            n_fail++;
            $display("FAIL corrupt got e=%0d err=%b first=%h w=%0d want e=1 err=1 first=02000005 w=4",
                     rx_err_count, rx_err, rx_first_err_data, rx_word_count);
        end
        // A second bad word must not overwrite the first captured error.
        step(1'b1, 32'h02001234, 4'hF);
        n_checks++;
        if (rx_err_count !== 2 || rx_first_err_data !== 32'h02000005) begin
            n_fail++;
            $display("FAIL corrupt_second got e=%0d first=%h want e=2 first=02000005",
                     rx_err_count, rx_first_err_data);
        end
        $display("test_corrupt: e=%0d first=%h", rx_err_count, rx_first_err_data);
    endtask

    task automatic test_short_packet();
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 32'h02000000 + i, 4'hF);
        step(1'b1, 32'hABCD0009, 4'h3);
        n_checks++;
        if (rx_packet_count !== 1 || rx_err_count !== 0 || rx_word_count !== 10) begin
            n_fail++;
            $display("FAIL short_pkt got p=%0d e=%0d w=%0d want p=1 e=0 w=10",
                     rx_packet_count, rx_err_count, rx_word_count);
        end
        for (int i = 10; i < 10 + WPP - 1; i++) step(1'b1, 32'h02000000 + i, 4'hF);
        n_checks++;
        if (rx_packet_count !== 1) begin
            n_fail++; $display("FAIL short_next_255 got p=%0d want 1", rx_packet_count);
        end
        step(1'b1, 32'h02000000 + 10 + WPP - 1, 4'hF);
        n_checks++;
        if (rx_packet_count !== 2 || rx_err_count !== 0) begin
            n_fail++;
            $display("FAIL short_next_256 got p=%0d e=%0d want p=2 e=0", rx_packet_count, rx_err_count);
        end
        $display("test_short_packet: p=%0d", rx_packet_count);
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 32'h02FFFFFE, 4'hF);
        step(1'b1, 32'h02FFFFFF, 4'hF);
        step(1'b1, 32'h02000000, 4'hF);
        step(1'b1, 32'h02000001, 4'hF);
        n_checks++;
        if (rx_err_count !== 1 || rx_first_err_data !== 32'h02FFFFFE || rx_word_count !== 4) begin
            n_fail++;
            $display("FAIL wrap got e=%0d first=%h w=%0d want e=1 first=02fffffe w=4",
                     rx_err_count, rx_first_err_data, rx_word_count);
        end
        $display("test_wrap: e=%0d", rx_err_count);
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 20; i++) begin
            pc_rx_empty = (i < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (pc_rx_rd_en !== !pc_rx_empty) begin
                n_fail++;
                $display("FAIL handshake cycle %0d empty=%b got rd_en=%b want %b",
                         i, pc_rx_empty, pc_rx_rd_en, !pc_rx_empty);
            end
            @(negedge clk);
        end
        pc_rx_empty = 1'b0;
        $display("test_handshake done");
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [3:0]  be;
        logic        v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 9) < 8);
            be = ($urandom_range(0, 9) < 8) ? 4'hF : 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 9) < 7) ? ((CH << 24) | m_seq) : $urandom;
            pc_rx_empty = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (pc_rx_rd_en !== !pc_rx_empty) begin
                n_fail++; $display("FAIL rand_rd_en cycle %0d got %b want %b", i, pc_rx_rd_en, !pc_rx_empty);
            end
            step(v, d, be);
            n_checks++;
            if (rx_word_count !== m_words || rx_packet_count !== m_pkts ||
                rx_err_count !== 16'(m_errs) || rx_err !== m_err || rx_first_err_data !== m_first) begin
                n_fail++;
                $display("FAIL rand_state cycle %0d got w=%0d p=%0d e=%0d err=%b first=%h want w=%0d p=%0d e=%0d err=%b first=%h",
                         i, rx_word_count, rx_packet_count, rx_err_count, rx_err, rx_first_err_data,
                         m_words, m_pkts, m_errs, m_err, m_first);
            end
        end
        pc_rx_empty = 1'b0;
        $display("test_random: w=%0d p=%0d e=%0d", m_words, m_pkts, m_errs);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h02000000 + i, 4'hF);
        step(1'b1, 32'h02000077, 4'hF);
        // reset coincides with a valid word, which must be dropped
        reset = 1'b1;
        step(1'b1, 32'h02999999, 4'hF);
        model_reset();
        reset = 1'b0;
        n_checks++;
        if (rx_word_count !== 0 || rx_packet_count !== 0 || rx_err_count !== 0 ||
            rx_err !== 0 || rx_first_err_data !== 0) begin
            n_fail++;
            $display("FAIL reset_mid got w=%0d p=%0d e=%0d err=%b first=%h want all 0",
                     rx_word_count, rx_packet_count, rx_err_count, rx_err, rx_first_err_data);
        end
        step(1'b1, 32'h02000000, 4'hF);
        step(1'b1, 32'h02000001, 4'hF);
        n_checks++;
        if (rx_word_count !== 2 || rx_err_count !== 0 || rx_err !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart got w=%0d e=%0d err=%b want w=2 e=0 err=0",
                     rx_word_count, rx_err_count, rx_err);
        end
        $display("test_reset_mid: w=%0d", rx_word_count);
    endtask

    initial begin
        reset = 1'b1; pc_rx_valid = 1'b0; pc_rx_empty = 1'b0;
        pc_rx_data = '0; pc_rx_be = 4'hF;
        @(negedge clk);
        test_reset();
        test_in_order();
        test_corrupt();
        test_short_packet();
        test_wrap();
        test_handshake();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
